irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Latches interrupt requests from peripherals plus the NMI line and arbitrates them by programmable level.
//  Presents one request at a time to the s1c88 core and retires it on the core's iack handshake.
//  Sits between the peripheral blocks and the core's exception inputs.
//  Configured by the system bus through a byte-wide register file.
// PARAMETERS
//  NUM_SOURCES   32   maskable sources (1..32); unused bits read 0, writes ignored
//  NMI_INDEX     32   vector index reported for NMI (must be >= NUM_SOURCES)
// PORTS
//  clk            in   1   core clock; all logic on posedge
//  reset_n        in   1   asynchronous, active-low reset
//  irq_in         in   N   peripheral request lines, rising-edge triggered, synchronous to clk
//  nmi_in         in   1   non-maskable request, rising-edge triggered
//  reg_addr       in   5   register address
//  reg_wdata      in   8   register write data
//  reg_write      in   1   1-cycle write strobe
//  reg_rdata      out  8   read data, combinational from reg_addr
//  cpu_imask      in   2   core interrupt mask level; maskable taken only if level > cpu_imask
//  cpu_irq_req    out  1   request to core
//  cpu_irq_level  out  2   level of presented request (1..3; 3 for NMI)
//  cpu_irq_nmi    out  1   presented request is NMI
//  cpu_irq_index  out  6   vector index of presented request
//  cpu_iack       in   1   core acknowledge; held high through vector fetch
// BEHAVIOUR
//  Reset: all outputs 0, pending/enable/priority 0, irq_in_d/nmi_d 0, state IDLE.
//  Edge detect: pend[i] set in cycle after irq_in[i] & ~irq_in_d[i]; NMI likewise into nmi_pend.
//  Registers: 0x00-0x03 ENABLE bytes (bit i = source i); 0x04-0x07 PENDING (read; write-1-clears).
//  0x08-0x0F PRIORITY, 2 bits/source, source i at byte 8+i/4, bits [2*(i%4)+:2]; 0 = never taken.
//  Unmapped addresses read 0x00, writes ignored.
//  Same-cycle new edge and W1C on one bit: set wins.
//  Eligible(i) = pend & en & prio != 0 & prio > cpu_imask. NMI is always eligible.
//  Winner: NMI first, else highest prio, ties -> lowest index. Combinational, no latency.
//  FSM:
//   IDLE: winner exists -> latch level/index/nmi, REQUEST; outputs valid same cycle as cpu_irq_req.
//   REQUEST: cpu_irq_req=1.
//    Strictly higher-level winner appears -> relatch, stay in REQUEST; req stays high.
//    Latched source no longer eligible (W1C, disable, mask raised) -> req=0, IDLE next cycle.
//    cpu_iack=1 -> clear latched pend bit (or nmi_pend), ACK; req drops next cycle.
//   ACK: req=0, latched level/index held; wait cpu_iack=0 -> IDLE. Re-arbitration only from IDLE.
//  Latency: edge at cycle t -> pend at t+1 -> req at t+2 when idle.
//  iack outside REQUEST is ignored. A new edge on the acked source while in ACK re-pends it.
//  reset_n assert mid-handshake: immediate return to IDLE, all state cleared.
// STRUCTURE
//  Package irq_pkg: state enum {IDLE,REQUEST,ACK}, register address localparams, irq_level_t (2-bit).
//  Sub-module irq_arbiter: combinational eligible mask + priority/index search, outputs valid/level/index.
//  Top holds edge detect, register file, FSM.
// TESTING
//  Reset: all outputs 0, all registers read 0x00.
//  Single source: en[5]=1, prio[5]=2, imask=0; pulse irq_in[5].
//   -> req at +2 cycles, level=2, index=5; iack -> pend[5]=0, req=0; iack low -> IDLE.
//  Tie and priority:
//   src3 prio1 and src9 prio3 pend together -> index 9 first.
//   src2 and src7 both prio2 -> index 2 first.
//  Preempt: in REQUEST with src4 prio1, src6 prio3 fires -> index changes to 6 with req held high.
//  Withdraw: in REQUEST, W1C 0x04 bit latched -> req=0 next cycle, state IDLE. Set+W1C same cycle -> bit stays 1.
//  Masking/NMI:
//   imask=3 blocks all maskable sources (none presented).
//   nmi_in edge -> req, nmi=1, level=3, index=32; nmi_pend cleared on iack.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types, register map and helpers for the s1c88 interrupt controller.
package irq_pkg;

  typedef logic [1:0] irq_level_t;
  typedef logic [1:0] irq_state_t;

  localparam irq_state_t IDLE    = 2'd0;
  localparam irq_state_t REQUEST = 2'd1;
  localparam irq_state_t ACK     = 2'd2;

  localparam logic [4:0] ADDR_ENABLE  = 5'h00;
  localparam logic [4:0] ADDR_PENDING = 5'h04;
  localparam logic [4:0] ADDR_PRIO    = 5'h08;

  function automatic logic [31:0] src_mask(int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [63:0] prio_mask(int n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) m[2*i +: 2] = 2'b11;
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational eligibility and winner search: NMI first, then highest level, ties to lowest index.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int NMI_INDEX = 32
) (
  input  logic [31:0] pend,
  input  logic [31:0] en,
  input  logic [63:0] prio,
  input  logic [1:0]  imask,
  input  logic        nmi_pend,
  output logic [31:0] elig,
  output logic        win_vld,
  output logic        win_nmi,
  output logic [1:0]  win_level,
  output logic [5:0]  win_index
);

  always_comb begin
    irq_level_t lvl;
    lvl  = '0;
    elig = '0;
    for (int i = 0; i < 32; i++) begin
      lvl     = prio[2*i +: 2];
      elig[i] = pend[i] & en[i] & (lvl != 2'd0) & (lvl > imask);
    end
  end

  always_comb begin
    win_vld   = 1'b0;
    win_nmi   = 1'b0;
    win_level = 2'd0;
    win_index = 6'd0;
    if (nmi_pend) begin
      win_vld   = 1'b1;
      win_nmi   = 1'b1;
      win_level = 2'd3;
      win_index = 6'(NMI_INDEX);
    end else begin
      // Descending scan with >= lets the lowest index win a tie.
      for (int i = 31; i >= 0; i--) begin
        if (elig[i] && (prio[2*i +: 2] >= win_level)) begin
          win_vld   = 1'b1;
          win_level = prio[2*i +: 2];
          win_index = 6'(i);
        end
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-latched interrupt controller: register file, edge detect and request/ack FSM toward the s1c88 core.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SOURCES = 32,
  parameter int NMI_INDEX   = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SOURCES-1:0] irq_in,
  input  logic                   nmi_in,
  input  logic [4:0]             reg_addr,
  input  logic [7:0]             reg_wdata,
  input  logic                   reg_write,
  output logic [7:0]             reg_rdata,
  input  logic [1:0]             cpu_imask,
  output logic                   cpu_irq_req,
  output logic [1:0]             cpu_irq_level,
  output logic                   cpu_irq_nmi,
  output logic [5:0]             cpu_irq_index,
  input  logic                   cpu_iack
);

  localparam logic [31:0] SRC_MASK  = src_mask(NUM_SOURCES);
  localparam logic [63:0] PRIO_MASK = prio_mask(NUM_SOURCES);

  logic [31:0] irq_ext, irq_in_d, irq_edge, en, pend, w1c, ack_clr, elig;
  logic [63:0] prio;
  logic        nmi_d, nmi_edge, nmi_pend;
  irq_state_t  state;
  logic        lat_nmi;
  irq_level_t  lat_level;
  logic [5:0]  lat_index;
  logic        win_vld, win_nmi, lat_elig, ack_take, preempt;
  logic [1:0]  win_level;
  logic [5:0]  win_index;

  assign irq_ext  = 32'(irq_in) & SRC_MASK;
  assign irq_edge = irq_ext & ~irq_in_d;
  assign nmi_edge = nmi_in & ~nmi_d;

  irq_arbiter #(.NMI_INDEX(NMI_INDEX)) u_arb (
    .pend      (pend),
    .en        (en),
    .prio      (prio),
    .imask     (cpu_imask),
    .nmi_pend  (nmi_pend),
    .elig      (elig),
    .win_vld   (win_vld),
    .win_nmi   (win_nmi),
    .win_level (win_level),
    .win_index (win_index)
  );

  // Request is withdrawn the moment the latched source stops being eligible.
  assign lat_elig    = lat_nmi | elig[lat_index[4:0]];
  assign cpu_irq_req = (state == REQUEST) & lat_elig;
  assign ack_take    = cpu_irq_req & cpu_iack;
  assign preempt     = cpu_irq_req & win_vld & (win_level > lat_level);

  assign cpu_irq_level = lat_level;
  assign cpu_irq_nmi   = lat_nmi;
  assign cpu_irq_index = lat_index;

  always_comb begin
    w1c     = '0;
    ack_clr = '0;
    if (reg_write && (reg_addr[4:2] == ADDR_PENDING[4:2]))
      w1c[{reg_addr[1:0], 3'b000} +: 8] = reg_wdata;
    if (ack_take && !lat_nmi)
      ack_clr[lat_index[4:0]] = 1'b1;
  end

  always_comb begin
    reg_rdata = 8'h00;
    case (reg_addr[4:2])
      3'b000:         reg_rdata = en[{reg_addr[1:0], 3'b000} +: 8];
      3'b001:         reg_rdata = pend[{reg_addr[1:0], 3'b000} +: 8];
      3'b010, 3'b011: reg_rdata = prio[{reg_addr[2:0], 3'b000} +: 8];
      default:        reg_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_in_d <= '0;
      nmi_d    <= 1'b0;
      pend     <= '0;
      nmi_pend <= 1'b0;
      en       <= '0;
      prio     <= '0;
    end else begin
      irq_in_d <= irq_ext;
      nmi_d    <= nmi_in;
      // A fresh edge beats both W1C and acknowledge on the same bit.
      pend     <= ((pend & ~w1c & ~ack_clr) | irq_edge) & SRC_MASK;
      nmi_pend <= (nmi_pend & ~(ack_take & lat_nmi)) | nmi_edge;
      if (reg_write && (reg_addr[4:2] == ADDR_ENABLE[4:2]))
        en[{reg_addr[1:0], 3'b000} +: 8] <= reg_wdata & SRC_MASK[{reg_addr[1:0], 3'b000} +: 8];
      if (reg_write && (reg_addr[4:3] == ADDR_PRIO[4:3]))
        prio[{reg_addr[2:0], 3'b000} +: 8] <= reg_wdata & PRIO_MASK[{reg_addr[2:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lat_nmi   <= 1'b0;
      lat_level <= '0;
      lat_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            lat_nmi   <= win_nmi;
            lat_level <= win_level;
            lat_index <= win_index;
            state     <= REQUEST;
          end
        end
        REQUEST: begin
          if (!lat_elig) begin
            state <= IDLE;
          end else if (cpu_iack) begin
            state <= ACK;
          end else if (preempt) begin
            lat_nmi   <= win_nmi;
            lat_level <= win_level;
            lat_index <= win_index;
          end
        end
        ACK: begin
          if (!cpu_iack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed-vector bench for irq_controller with hand-computed expectations.
module tb_irq_controller;

  logic        clk;
  logic        reset_n;
  logic [31:0] irq_in;
  logic        nmi_in;
  logic [4:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_write;
  logic [7:0]  reg_rdata;
  logic [1:0]  cpu_imask;
  logic        cpu_irq_req;
  logic [1:0]  cpu_irq_level;
  logic        cpu_irq_nmi;
  logic [5:0]  cpu_irq_index;
  logic        cpu_iack;

  int n_cmp;
  int n_err;

  irq_controller #(.NUM_SOURCES(32), .NMI_INDEX(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .irq_in        (irq_in),
    .nmi_in        (nmi_in),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_write     (reg_write),
    .reg_rdata     (reg_rdata),
    .cpu_imask     (cpu_imask),
    .cpu_irq_req   (cpu_irq_req),
    .cpu_irq_level (cpu_irq_level),
    .cpu_irq_nmi   (cpu_irq_nmi),
    .cpu_irq_index (cpu_irq_index),
    .cpu_iack      (cpu_iack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_write = 1'b1;
    step(1);
    reg_write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
    reg_addr = a;
    #1;
    chk(tag, {24'h0, reg_rdata}, {24'h0, exp});
  endtask

  task automatic pulse(input logic [31:0] m);
    irq_in = m;
    step(1);
    irq_in = '0;
  endtask

  task automatic ack();
    cpu_iack = 1'b1;
    step(1);
    cpu_iack = 1'b0;
    step(1);
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [1:0] lvl,
                         input logic nmi, input logic [5:0] idx);
    chk({tag, "_req"}, {31'h0, cpu_irq_req}, {31'h0, req});
    chk({tag, "_lvl"}, {30'h0, cpu_irq_level}, {30'h0, lvl});
    chk({tag, "_nmi"}, {31'h0, cpu_irq_nmi}, {31'h0, nmi});
    chk({tag, "_idx"}, {26'h0, cpu_irq_index}, {26'h0, idx});
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    irq_in    = '0;
    nmi_in    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    reg_write = 1'b0;
    cpu_imask = 2'd0;
    cpu_iack  = 1'b0;
    step(2);
    chk_req("rst", 1'b0, 2'd0, 1'b0, 6'd0);
    reset_n = 1'b1;
    step(1);
    for (int a = 0; a < 32; a++) rd_chk("rst_reg", 5'(a), 8'h00);

    // Single source 5 at level 2
    wr(5'h00, 8'h20);
    wr(5'h09, 8'h08);
    wr(5'h10, 8'hFF);
    rd_chk("en0", 5'h00, 8'h20);
    rd_chk("prio9", 5'h09, 8'h08);
    rd_chk("unmapped", 5'h10, 8'h00);
    pulse(32'h0000_0020);
    chk("single_t1_req", {31'h0, cpu_irq_req}, 32'h0);
    rd_chk("single_pend", 5'h04, 8'h20);
    step(1);
    chk_req("single", 1'b1, 2'd2, 1'b0, 6'd5);
    cpu_iack = 1'b1;
    step(1);
    chk_req("single_ack", 1'b0, 2'd2, 1'b0, 6'd5);
    rd_chk("single_pend_clr", 5'h04, 8'h00);
    cpu_iack = 1'b0;
    step(1);
    chk("single_idle_req", {31'h0, cpu_irq_req}, 32'h0);

    // Tie and priority setup: enable 2,3,4,6,7,9
    wr(5'h00, 8'hDC);
    wr(5'h01, 8'h02);
    wr(5'h08, 8'h60);
    wr(5'h09, 8'hB9);
    wr(5'h0A, 8'h0C);
    pulse(32'h0000_0208);
    step(1);
    chk_req("prio_first", 1'b1, 2'd3, 1'b0, 6'd9);
    ack();
    step(1);
    chk_req("prio_second", 1'b1, 2'd1, 1'b0, 6'd3);
    ack();
    pulse(32'h0000_0084);
    step(1);
    chk_req("tie_first", 1'b1, 2'd2, 1'b0, 6'd2);
    ack();
    step(1);
    chk_req("tie_second", 1'b1, 2'd2, 1'b0, 6'd7);
    ack();

    // Preempt src4 (level 1) by src6 (level 3)
    pulse(32'h0000_0010);
    step(1);
    chk_req("pre_low", 1'b1, 2'd1, 1'b0, 6'd4);
    pulse(32'h0000_0040);
    chk_req("pre_hold", 1'b1, 2'd1, 1'b0, 6'd4);
    step(1);
    chk_req("pre_high", 1'b1, 2'd3, 1'b0, 6'd6);
    ack();
    step(1);
    chk_req("pre_back", 1'b1, 2'd1, 1'b0, 6'd4);

    // Withdraw via W1C, then set+W1C collision
    wr(5'h04, 8'h10);
    chk("wd_req_drop", {31'h0, cpu_irq_req}, 32'h0);
    step(1);
    chk("wd_idle_req", {31'h0, cpu_irq_req}, 32'h0);
    rd_chk("wd_pend", 5'h04, 8'h00);
    irq_in    = 32'h0000_0010;
    reg_addr  = 5'h04;
    reg_wdata = 8'h10;
    reg_write = 1'b1;
    step(1);
    reg_write = 1'b0;
    irq_in    = '0;
    rd_chk("set_wins", 5'h04, 8'h10);
    step(1);
    chk_req("set_req", 1'b1, 2'd1, 1'b0, 6'd4);

    // Masking and NMI
    cpu_imask = 2'd3;
    #1;
    chk("mask_drop", {31'h0, cpu_irq_req}, 32'h0);
    step(1);
    pulse(32'h0000_0040);
    step(1);
    chk("mask_none", {31'h0, cpu_irq_req}, 32'h0);
    rd_chk("mask_pend", 5'h04, 8'h50);
    nmi_in = 1'b1;
    step(1);
    nmi_in = 1'b0;
    step(1);
    chk_req("nmi", 1'b1, 2'd3, 1'b1, 6'd32);
    cpu_iack = 1'b1;
    step(1);
    chk("nmi_ack_req", {31'h0, cpu_irq_req}, 32'h0);
    cpu_iack = 1'b0;
    step(2);
    chk("nmi_cleared", {31'h0, cpu_irq_req}, 32'h0);
    cpu_imask = 2'd0;
    step(1);
    chk_req("unmask", 1'b1, 2'd3, 1'b0, 6'd6);

    // Reset mid-handshake
    reset_n = 1'b0;
    #1;
    chk_req("mid_rst", 1'b0, 2'd0, 1'b0, 6'd0);
    rd_chk("mid_rst_pend", 5'h04, 8'h00);
    rd_chk("mid_rst_prio", 5'h09, 8'h00);
    reset_n = 1'b1;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
